// File: rtl/jtframe_sdram64_sched_pkg.sv
// Shared encodings for the SDRAM command-bus scheduler.
package jtframe_sdram64_sched_pkg;

  localparam int unsigned CMD_W   = 4;
  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned BANK_W  = 2;
  localparam int unsigned NBANK   = 4;

  // SDRAM commands as {CS,RAS,CAS,WE}
  localparam logic [CMD_W-1:0] CMD_NOP       = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_REFRESH   = 4'b0001;

  // Precharge-all address: only A10 set
  localparam logic [ADDR_W-1:0] A_PRECH_ALL = 13'h0400;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_PRECH    = 3'd2,
    ST_WAIT_RP  = 3'd3,
    ST_REF      = 3'd4,
    ST_WAIT_RFC = 3'd5
  } rfsh_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jtframe_rr_arb4.sv
// Combinational 4-way round-robin pick starting the search at ptr_i.
module jtframe_rr_arb4
  import jtframe_sdram64_sched_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] gnt_o,
  output logic [1:0] idx_o
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the nearest requester to ptr wins
  always_comb begin
    gnt_o = '0;
    idx_o = ptr_i;
    cand  = ptr_i;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_i + 2'(i);
      if (req_i[cand]) begin
        gnt_o = 4'b0001 << cand;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/jtframe_sdram64_sched.sv
// Shares the SDRAM command bus between four bank controllers and inserts
// periodic precharge-all + auto-refresh sequences.
module jtframe_sdram64_sched
  import jtframe_sdram64_sched_pkg::*;
#(
  parameter int unsigned BANKS   = 4,
  parameter int unsigned REF_CYC = 780,
  parameter int unsigned TRP     = 3,
  parameter int unsigned TRFC    = 8
)(
  input  logic                     rst,
  input  logic                     clk,
  input  logic [BANKS-1:0]         br_i,
  input  logic [BANKS*CMD_W-1:0]   bank_cmd_i,
  input  logic [BANKS*ADDR_W-1:0]  bank_a_i,
  input  logic [BANKS-1:0]         bank_dbusy_i,
  input  logic [BANKS-1:0]         bank_dbusy64_i,
  input  logic [BANKS-1:0]         bank_dqm_i,
  input  logic [BANKS-1:0]         bank_pact_i,
  input  logic [BANKS-1:0]         bank_idle_i,
  output logic [BANKS-1:0]         bg_o,
  output logic                     all_dbusy_o,
  output logic                     all_dbusy64_o,
  output logic                     all_dqm_o,
  output logic                     all_act_o,
  output logic [BANKS-1:0]         set_prech_o,
  output logic [CMD_W-1:0]         sdram_cmd_o,
  output logic [ADDR_W-1:0]        sdram_a_o,
  output logic [BANK_W-1:0]        sdram_ba_o,
  output logic                     rfsh_busy_o
);

  localparam int unsigned REF_W      = $clog2(REF_CYC);
  localparam int unsigned WAIT_W     = max_u(1, $clog2(max_u(TRP, TRFC)));
  localparam int unsigned WAIT_RP_LD  = (TRP  > 1) ? TRP  - 2 : 0;
  localparam int unsigned WAIT_RFC_LD = (TRFC > 1) ? TRFC - 2 : 0;

  rfsh_state_e         state_q, state_d;
  logic [REF_W-1:0]    ref_cnt_q, ref_cnt_d;
  logic                pend_q, pend_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic [BANK_W-1:0]   ptr_q, ptr_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [BANK_W-1:0]   ba_q, ba_d;
  logic [BANKS-1:0]    set_prech_q, set_prech_d;

  logic                ref_wrap;
  logic                grant_en;
  logic [NBANK-1:0]    arb_req;
  logic [NBANK-1:0]    arb_gnt;
  logic [BANK_W-1:0]   arb_idx;
  logic [CMD_W-1:0]    granted_cmd;
  logic [ADDR_W-1:0]   granted_a;
  logic [CMD_W-1:0]    fsm_cmd;
  logic [ADDR_W-1:0]   fsm_a;

  // New grants only while running with no refresh pending
  assign grant_en = (state_q == ST_RUN) && !pend_q;
  assign arb_req  = grant_en ? br_i : '0;

  jtframe_rr_arb4 u_arb (
    .req_i (arb_req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign granted_cmd = bank_cmd_i[arb_idx*CMD_W +: CMD_W];
  assign granted_a   = bank_a_i[arb_idx*ADDR_W +: ADDR_W];

  // Shared busy flags are plain ORs, valid in every state
  assign all_dbusy_o   = |bank_dbusy_i;
  assign all_dbusy64_o = |bank_dbusy64_i;
  assign all_dqm_o     = |bank_dqm_i;
  assign all_act_o     = |bank_pact_i;

  assign bg_o        = arb_gnt;
  assign rfsh_busy_o = pend_q | (state_q != ST_RUN);

  assign sdram_cmd_o = cmd_q;
  assign sdram_a_o   = a_q;
  assign sdram_ba_o  = ba_q;
  assign set_prech_o = set_prech_q;

  // Next-state: refresh counter, refresh FSM, round-robin pointer, pin mux
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    pend_d      = pend_q;
    ptr_d       = ptr_q;
    fsm_cmd     = CMD_NOP;
    fsm_a       = a_q;
    set_prech_d = '0;
    cmd_d       = CMD_NOP;
    a_d         = a_q;
    ba_d        = ba_q;

    ref_wrap  = (ref_cnt_q == REF_W'(REF_CYC - 1));
    ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + REF_W'(1);
    if (ref_wrap) pend_d = 1'b1;

    case (state_q)
      ST_RUN: begin
        if (pend_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((&bank_idle_i) && !all_dbusy64_o && !all_act_o) state_d = ST_PRECH;
      end
      ST_PRECH: begin
        fsm_cmd     = CMD_PRECHARGE;
        fsm_a       = A_PRECH_ALL;
        set_prech_d = '1;
        if (TRP > 1) begin
          state_d = ST_WAIT_RP;
          wcnt_d  = WAIT_W'(WAIT_RP_LD);
        end else begin
          state_d = ST_REF;
        end
      end
      ST_WAIT_RP: begin
        if (wcnt_q == '0) state_d = ST_REF;
        else              wcnt_d  = wcnt_q - WAIT_W'(1);
      end
      ST_REF: begin
        fsm_cmd = CMD_REFRESH;
        pend_d  = 1'b0;
        if (TRFC > 1) begin
          state_d = ST_WAIT_RFC;
          wcnt_d  = WAIT_W'(WAIT_RFC_LD);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WAIT_RFC: begin
        if (wcnt_q == '0) state_d = ST_RUN;
        else              wcnt_d  = wcnt_q - WAIT_W'(1);
      end
      default: state_d = ST_RUN;
    endcase

    if (|arb_gnt) begin
      cmd_d = granted_cmd;
      a_d   = granted_a;
      ba_d  = arb_idx;
      // Rotate only once the granted bank actually uses the bus
      if (granted_cmd != CMD_NOP) ptr_d = arb_idx + BANK_W'(1);
    end else begin
      cmd_d = fsm_cmd;
      a_d   = fsm_a;
    end
  end

  // Refresh FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Counters, pointer and SDRAM pin registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt_q   <= '0;
      pend_q      <= 1'b0;
      wcnt_q      <= '0;
      ptr_q       <= '0;
      cmd_q       <= CMD_NOP;
      a_q         <= '0;
      ba_q        <= '0;
      set_prech_q <= '0;
    end else begin
      ref_cnt_q   <= ref_cnt_d;
      pend_q      <= pend_d;
      wcnt_q      <= wcnt_d;
      ptr_q       <= ptr_d;
      cmd_q       <= cmd_d;
      a_q         <= a_d;
      ba_q        <= ba_d;
      set_prech_q <= set_prech_d;
    end
  end

endmodule
